// File: rtl/serial_pkg.sv
// Shared types and helpers for the bit-serial full subtractor that recovers
// the adder's first operand from its sum and second operand.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int MAX_WIDTH = 32;

    // Behavioural form of the borrow recurrence, for use outside the gate-level cell.
    function automatic logic borrow_next(input logic s, input logic b, input logic br);
        return (~s & b) | (~s & br) | (b & br);
    endfunction

endpackage

// File: rtl/serial_addend_recover_cell.sv
// One-bit full subtractor d = s - b - br in the same two-input/three-input
// NAND style as the adder cells, so glitch analysis carries over.
module full_subtractor_cell (
    input  logic s,
    input  logic b,
    input  logic br,
    output logic d,
    output logic br_out
);
    logic n1, n2, n3, x;
    logic m1, m2, m3;
    logic ns, t1, t2, t3;

    // d = (s ^ b) ^ br as two four-NAND XORs
    assign n1 = ~(s & b);
    assign n2 = ~(s & n1);
    assign n3 = ~(b & n1);
    assign x  = ~(n2 & n3);

    assign m1 = ~(x & br);
    assign m2 = ~(x & m1);
    assign m3 = ~(br & m1);
    assign d  = ~(m2 & m3);

    // br_out = ~s&b | ~s&br | b&br as NAND-NAND sum of products
    assign ns     = ~(s & s);
    assign t1     = ~(ns & b);
    assign t2     = ~(ns & br);
    assign t3     = ~(b & br);
    assign br_out = ~(t1 & t2 & t3);

endmodule

// File: rtl/serial_addend_recover.sv
// Bit-serial full subtractor: rebuilds operand a = sum - b (mod 2^WIDTH) and the
// adder carry-out from an LSB-first stream of (sum, b) bit pairs.
//
//   state | meaning
//   IDLE  | waiting for an LSB (in_first) pair; non-first pairs are dropped with frame_err
//   SHIFT | collecting bits 1..WIDTH-1; a fresh in_first restarts the word with frame_err
//   HOLD  | word and carry presented on out_*, input stalled until out_ready
module serial_addend_recover
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sum,
    input  logic             in_b,
    input  logic             in_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic             out_carry,
    output logic             frame_err
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_HOLD  = HOLD;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic             out_carry_q, out_carry_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_err_q, frame_err_d;

    logic accept;
    logic cell_br_in;
    logic cell_d;
    logic cell_br_out;

    assign in_ready = (state_q != ST_HOLD);
    assign accept   = in_valid & in_ready;

    // Bit 0 of a word always subtracts with zero borrow-in.
    assign cell_br_in = (state_q == ST_SHIFT) && !in_first ? br_q : 1'b0;

    full_subtractor_cell u_cell (
        .s      (in_sum),
        .b      (in_b),
        .br     (cell_br_in),
        .d      (cell_d),
        .br_out (cell_br_out)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        br_d        = br_q;
        sr_d        = sr_q;
        out_a_d     = out_a_q;
        out_carry_d = out_carry_q;
        out_valid_d = out_valid_q;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_first) begin
                        sr_d    = {cell_d, {(WIDTH-1){1'b0}}};
                        br_d    = cell_br_out;
                        count_d = CW'(1);
                        state_d = ST_SHIFT;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (accept) begin
                    if (in_first) begin
                        frame_err_d = 1'b1;
                        sr_d        = {cell_d, {(WIDTH-1){1'b0}}};
                        br_d        = cell_br_out;
                        count_d     = CW'(1);
                    end else begin
                        sr_d    = {cell_d, sr_q[WIDTH-1:1]};
                        br_d    = cell_br_out;
                        count_d = count_q + CW'(1);
                        if (count_q == CW'(WIDTH - 1)) begin
                            out_a_d     = {cell_d, sr_q[WIDTH-1:1]};
                            out_carry_d = cell_br_out;
                            out_valid_d = 1'b1;
                            state_d     = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    count_d     = '0;
                    br_d        = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            br_q        <= 1'b0;
            sr_q        <= '0;
            out_a_q     <= '0;
            out_carry_q <= 1'b0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            br_q        <= br_d;
            sr_q        <= sr_d;
            out_a_q     <= out_a_d;
            out_carry_q <= out_carry_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_a     = out_a_q;
    assign out_carry = out_carry_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_addend_recover.sv
// Self-checking bench: three instances (WIDTH 2, 8, 32) sharing stimulus, one selected
// at a time, checked against plain modular arithmetic on whole words.
module tb_serial_addend_recover;

    logic clk;
    logic rst_n;
    logic in_valid, in_sum, in_b, in_first, out_ready;
    int   sel;

    logic rdy0, ov0, oc0, fe0;
    logic rdy1, ov1, oc1, fe1;
    logic rdy2, ov2, oc2, fe2;
    logic [1:0]  oa0;
    logic [7:0]  oa1;
    logic [31:0] oa2;

    logic        rdy, ov, oc, fe;
    logic [31:0] oa;

    int errors;
    int checks;
    int fe_total;

    serial_addend_recover #(.WIDTH(2)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(rdy0),
        .in_sum(in_sum), .in_b(in_b), .in_first(in_first), .out_valid(ov0),
        .out_ready(out_ready), .out_a(oa0), .out_carry(oc0), .frame_err(fe0));

    serial_addend_recover #(.WIDTH(8)) u_dut_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(rdy1),
        .in_sum(in_sum), .in_b(in_b), .in_first(in_first), .out_valid(ov1),
        .out_ready(out_ready), .out_a(oa1), .out_carry(oc1), .frame_err(fe1));

    serial_addend_recover #(.WIDTH(32)) u_dut_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(rdy2),
        .in_sum(in_sum), .in_b(in_b), .in_first(in_first), .out_valid(ov2),
        .out_ready(out_ready), .out_a(oa2), .out_carry(oc2), .frame_err(fe2));

    always_comb begin
        rdy = rdy1; ov = ov1; oc = oc1; fe = fe1; oa = {24'd0, oa1};
        case (sel)
            0: begin rdy = rdy0; ov = ov0; oc = oc0; fe = fe0; oa = {30'd0, oa0}; end
            2: begin rdy = rdy2; ov = ov2; oc = oc2; fe = fe2; oa = oa2; end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (fe === 1'b1) fe_total++;

    function automatic logic [31:0] mask_w(input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return m[31:0];
    endfunction

    // Reference: operand a recovered as (s - b) mod 2^w
    function automatic logic [31:0] ref_a(input logic [31:0] s, input logic [31:0] b, input int w);
        return (s - b) & mask_w(w);
    endfunction

    // Reference: carry-out of the original addition a + b
    function automatic logic ref_carry(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [63:0] t;
        t = ({32'd0, a & mask_w(w)} + {32'd0, b & mask_w(w)}) >> w;
        return t[0];
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic s, input logic b, input logic f);
        in_valid = 1'b1;
        in_sum   = s;
        in_b     = b;
        in_first = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] s, input logic [31:0] b, input int w, input int gapmax);
        for (int i = 0; i < w; i++) begin
            idle(int'($urandom_range(0, gapmax)));
            beat(s[i], b[i], i == 0);
        end
    endtask

    task automatic collect();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic check_word(input string name, input logic [31:0] ea, input logic ec);
        checks++;
        if (ov !== 1'b1) begin
            errors++; $display("FAIL %s out_valid: got %b want 1", name, ov);
        end
        checks++;
        if (oa !== ea) begin
            errors++; $display("FAIL %s out_a: got %h want %h", name, oa, ea);
        end
        checks++;
        if (oc !== ec) begin
            errors++; $display("FAIL %s out_carry: got %b want %b", name, oc, ec);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (ov !== 1'b0 || oa !== 32'd0 || oc !== 1'b0 || fe !== 1'b0 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s: got valid=%b a=%h carry=%b ferr=%b ready=%b want 0 0 0 0 1",
                     name, ov, oa, oc, fe, rdy);
        end
    endtask

    task automatic test_reset();
        logic [31:0] a, b, s;
        sel = 1;
        check_idle_outputs("reset_initial");
        a = 32'h3C; b = 32'hA5; s = (a + b) & mask_w(8);
        send_word(s, b, 8, 0);
        checks++;
        if (oa !== 32'h3C) begin
            errors++; $display("FAIL reset_pre_hold out_a: got %h want 3c", oa);
        end
        #1 rst_n = 1'b0;
        #1 check_idle_outputs("reset_in_hold");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        beat(s[0], b[0], 1'b1);
        beat(s[1], b[1], 1'b0);
        beat(s[2], b[2], 1'b0);
        #1 rst_n = 1'b0;
        #1 check_idle_outputs("reset_mid_shift");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        a = 32'h81; b = 32'h7F; s = (a + b) & mask_w(8);
        send_word(s, b, 8, 0);
        check_word("reset_next_word", ref_a(s, b, 8), ref_carry(a, b, 8));
        collect();
    endtask

    task automatic test_basic();
        logic [31:0] s, b;
        logic early;
        sel = 1;
        b = 32'h33; s = (32'h5A + b) & mask_w(8);
        checks++;
        if (s !== 32'h8D) begin
            errors++; $display("FAIL basic_sum: got %h want 8d", s);
        end
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            beat(s[i], b[i], i == 0);
            if (i < 7 && ov !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++; $display("FAIL basic_latency: out_valid got 1 before 8th beat want 0");
        end
        check_word("basic_5a_33", 32'h5A, 1'b0);
        collect();
        checks++;
        if (ov !== 1'b0 || rdy !== 1'b1) begin
            errors++; $display("FAIL basic_release: got valid=%b ready=%b want 0 1", ov, rdy);
        end
    endtask

    task automatic test_gaps();
        logic [31:0] s, b;
        sel = 1;
        b = 32'h20; s = (32'hF0 + b) & mask_w(8);
        send_word(s, b, 8, 0);
        check_word("carry_f0_20", 32'hF0, 1'b1);
        collect();
        send_word(s, b, 8, 4);
        check_word("gaps_f0_20", 32'hF0, 1'b1);
        collect();
    endtask

    task automatic test_back_pressure();
        logic [31:0] a, b, s;
        sel = 1;
        a = 32'hC7; b = 32'h9E; s = (a + b) & mask_w(8);
        send_word(s, b, 8, 1);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rdy !== 1'b0 || ov !== 1'b1 || oa !== 32'hC7 || oc !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_cycle%0d: got ready=%b valid=%b a=%h carry=%b want 0 1 c7 1",
                         c, rdy, ov, oa, oc);
            end
            idle(1);
        end
        collect();
        checks++;
        if (ov !== 1'b0 || rdy !== 1'b1) begin
            errors++; $display("FAIL backpressure_release: got valid=%b ready=%b want 0 1", ov, rdy);
        end
    endtask

    task automatic test_framing();
        logic [31:0] s1, b1, s2, b2;
        int fe0_snap;
        sel = 1;
        b1 = 32'h34; s1 = (32'h12 + b1) & mask_w(8);
        b2 = 32'h7E; s2 = (32'hC3 + b2) & mask_w(8);
        fe0_snap = fe_total;
        for (int i = 0; i < 4; i++) beat(s1[i], b1[i], i == 0);
        beat(s2[0], b2[0], 1'b1);
        checks++;
        if (fe !== 1'b1) begin
            errors++; $display("FAIL framing_pulse: got frame_err=%b want 1", fe);
        end
        for (int i = 1; i < 8; i++) beat(s2[i], b2[i], 1'b0);
        checks++;
        if (fe_total - fe0_snap != 1) begin
            errors++; $display("FAIL framing_count: got %0d pulses want 1", fe_total - fe0_snap);
        end
        check_word("framing_second_word", 32'hC3, ref_carry(32'hC3, b2, 8));
        collect();
    endtask

    task automatic test_idle_frame_err();
        int snap;
        sel = 1;
        snap = fe_total;
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b0, 1'b1, 1'b0);
        idle(2);
        checks++;
        if (fe_total - snap != 2 || ov !== 1'b0 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL idle_drop: got pulses=%0d valid=%b ready=%b want 2 0 1",
                     fe_total - snap, ov, rdy);
        end
    endtask

    task automatic test_random(input int idx, input int w, input int words);
        logic [31:0] a, b, s;
        int snap;
        sel = idx;
        snap = fe_total;
        for (int n = 0; n < words; n++) begin
            a = $urandom & mask_w(w);
            b = $urandom & mask_w(w);
            s = (a + b) & mask_w(w);
            send_word(s, b, w, 1);
            check_word($sformatf("random_w%0d_word%0d", w, n), ref_a(s, b, w), ref_carry(a, b, w));
            checks++;
            if (oa !== a) begin
                errors++; $display("FAIL random_w%0d_word%0d operand: got %h want %h", w, n, oa, a);
            end
            out_ready = 1'b0;
            idle(int'($urandom_range(0, 2)));
            collect();
        end
        checks++;
        if (fe_total != snap) begin
            errors++; $display("FAIL random_w%0d_no_frame_err: got %0d pulses want 0", w, fe_total - snap);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        fe_total  = 0;
        sel       = 1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = 1'b0;
        in_b      = 1'b0;
        in_first  = 1'b0;
        out_ready = 1'b0;
        idle(3);
        check_idle_outputs("reset_asserted");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        test_reset();
        test_basic();
        test_gaps();
        test_back_pressure();
        test_framing();
        test_idle_frame_err();
        test_random(0, 2, 1000);
        test_random(1, 8, 1000);
        test_random(2, 32, 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
